// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings and sizing for the multiply/divide unit
package muldiv_pkg;

  localparam int MD_WIDTH   = 32;
  localparam int ITER_COUNT = MD_WIDTH;
  localparam int CNT_W      = $clog2(ITER_COUNT) + 1;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - request/result bundle between the register bank side and the multiply/divide unit
interface muldiv_if
  import muldiv_pkg::*;
#(
  parameter int N = MD_WIDTH
) ();

  logic         start;
  logic [1:0]   op;
  logic [N-1:0] operand_a;
  logic [N-1:0] operand_b;
  logic         busy;
  logic         done;
  logic [N-1:0] hi;
  logic [N-1:0] lo;

  modport master (
    output start, op, operand_a, operand_b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, operand_a, operand_b,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/muldiv_negate.sv
// rtl/muldiv_negate.sv - N-bit conditional two's-complement negate
module muldiv_negate #(
  parameter int N = 32
) (
  input  logic [N-1:0] in,
  input  logic         neg,
  output logic [N-1:0] out
);

  assign out = neg ? (~in + N'(1)) : in;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - one-bit-per-cycle MULT/MULTU/DIV/DIVU with HI/LO result registers
// Define MULDIV_SIGNED_EN for signed MULT/DIV; otherwise every op is treated as unsigned.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int N = MD_WIDTH
) (
  input logic      clk,
  input logic      rst,
  muldiv_if.slave  bus
);

  localparam int CW = $clog2(N) + 1;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q;
  logic [2*N-1:0] acc_q, acc_next;
  logic [N-1:0]   opr_q;
  logic           is_div_q;
  logic [N-1:0]   hi_q, lo_q;
  logic           done_q;
  logic [N-1:0]   mag_a, mag_b, res_hi, res_lo;
  logic [N:0]     mul_sum, div_trial;
  logic           accept, op_is_div;
  op_e            op_in;

  assign op_in     = op_e'(bus.op);
  assign op_is_div = (op_in == OP_DIV) || (op_in == OP_DIVU);
  assign accept    = (state_q == IDLE) && bus.start;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = CALC;
      CALC:    if (cnt_q == CW'(N - 1)) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // acc_q holds {upper product, multiplier} for multiply and {remainder, dividend/quotient} for divide.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, opr_q} : {(N+1){1'b0}});
    div_trial = acc_q[2*N-1:N-1] - {1'b0, opr_q};
    if (is_div_q)
      acc_next = div_trial[N] ? {acc_q[2*N-2:0], 1'b0}
                              : {div_trial[N-1:0], acc_q[N-2:0], 1'b1};
    else
      acc_next = {mul_sum, acc_q[N-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      opr_q    <= '0;
      is_div_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= (state_q == FIX);
      case (state_q)
        IDLE: if (accept) begin
          cnt_q    <= '0;
          is_div_q <= op_is_div;
          opr_q    <= op_is_div ? mag_b : mag_a;
          acc_q    <= {{N{1'b0}}, (op_is_div ? mag_a : mag_b)};
        end
        CALC: begin
          acc_q <= acc_next;
          cnt_q <= cnt_q + CW'(1);
        end
        FIX: begin
          hi_q <= res_hi;
          lo_q <= res_lo;
        end
        default: ;
      endcase
    end
  end

`ifdef MULDIV_SIGNED_EN
  logic         signed_op, sa_q, flip_q, dz_q, lo_zero, neg_hi;
  logic [N-1:0] neg_hi_out;

  assign signed_op = (op_in == OP_MULT) || (op_in == OP_DIV);

  muldiv_negate #(.N(N)) u_abs_a (.in(bus.operand_a), .neg(signed_op & bus.operand_a[N-1]), .out(mag_a));
  muldiv_negate #(.N(N)) u_abs_b (.in(bus.operand_b), .neg(signed_op & bus.operand_b[N-1]), .out(mag_b));

  always_ff @(posedge clk) begin
    if (rst) begin
      sa_q   <= 1'b0;
      flip_q <= 1'b0;
      dz_q   <= 1'b0;
    end else if (accept) begin
      sa_q   <= signed_op & bus.operand_a[N-1];
      flip_q <= signed_op & (bus.operand_a[N-1] ^ bus.operand_b[N-1]);
      dz_q   <= op_is_div & (bus.operand_b == '0);
    end
  end

  // 2N-bit product negate split in halves: the upper half only takes the +1 carry when the lower half is zero.
  assign lo_zero = (acc_q[N-1:0] == '0);
  assign neg_hi  = is_div_q ? (sa_q & ~dz_q) : (flip_q & lo_zero);

  muldiv_negate #(.N(N)) u_fix_lo (.in(acc_q[N-1:0]),   .neg(flip_q & ~dz_q), .out(res_lo));
  muldiv_negate #(.N(N)) u_fix_hi (.in(acc_q[2*N-1:N]), .neg(neg_hi),        .out(neg_hi_out));

  assign res_hi = (!is_div_q && flip_q && !lo_zero) ? ~acc_q[2*N-1:N] : neg_hi_out;
`else
  assign mag_a  = bus.operand_a;
  assign mag_b  = bus.operand_b;
  assign res_hi = acc_q[2*N-1:N];
  assign res_lo = acc_q[N-1:0];
`endif

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized and directed checks of muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  muldiv_if #(.N(32)) bus ();

  muldiv_unit #(.N(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic              sgn;
    logic signed [63:0] sa, sb, p, qq, rr;
    logic [31:0]       mag;
`ifdef MULDIV_SIGNED_EN
    sgn = ~op[0];
`else
    sgn = 1'b0;
`endif
    sa = sgn ? $signed({{32{a[31]}}, a}) : $signed({32'b0, a});
    sb = sgn ? $signed({{32{b[31]}}, b}) : $signed({32'b0, b});
    if (!op[1]) begin
      p = sa * sb;
      return p;
    end
    if (b == 32'd0) begin
      mag = (sa < 0) ? 32'(-sa) : 32'(sa);
      return {mag, 32'hFFFF_FFFF};
    end
    qq = sa / sb;
    rr = sa % sb;
    return {rr[31:0], qq[31:0]};
  endfunction

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] h, output logic [31:0] l, output int lat, output int busy_bad);
    bus.start = 1'b1;
    bus.op = op;
    bus.operand_a = a;
    bus.operand_b = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = -1;
    busy_bad = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        lat = k;
        break;
      end
      if (!bus.busy) busy_bad++;
    end
    h = bus.hi;
    l = bus.lo;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.op = 2'd0;
    bus.operand_a = '0;
    bus.operand_b = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_vec++; if (bus.hi !== 32'd0) begin n_err++; $display("FAIL reset_hi: got %h want 0", bus.hi); end
    n_vec++; if (bus.lo !== 32'd0) begin n_err++; $display("FAIL reset_lo: got %h want 0", bus.lo); end
  endtask

  task automatic test_multu_latency();
    logic [31:0] h, l;
    int lat, bb;
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, h, l, lat, bb);
    n_vec++; if (h !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL multu_hi: got %h want fffffffe", h); end
    n_vec++; if (l !== 32'h0000_0001) begin n_err++; $display("FAIL multu_lo: got %h want 00000001", l); end
    n_vec++; if (lat !== 33) begin n_err++; $display("FAIL multu_latency: got %0d want 33", lat); end
    n_vec++; if (bb !== 0) begin n_err++; $display("FAIL multu_busy: busy low in %0d cycles want 0", bb); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL done_cycle_busy: got %b want 0", bus.busy); end
    @(posedge clk); #1;
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL done_width: got %b want 0", bus.done); end
  endtask

  task automatic test_directed();
    logic [31:0] h, l, eh;
    int lat, bb;
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd5, h, l, lat, bb);
`ifdef MULDIV_SIGNED_EN
    eh = 32'hFFFF_FFFF;
`else
    eh = 32'h0000_0004;
`endif
    n_vec++; if (h !== eh) begin n_err++; $display("FAIL mult_hi: got %h want %h", h, eh); end
    n_vec++; if (l !== 32'hFFFF_FFF1) begin n_err++; $display("FAIL mult_lo: got %h want fffffff1", l); end
`ifdef MULDIV_SIGNED_EN
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, h, l, lat, bb);
    n_vec++; if (l !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_lo: got %h want fffffffd", l); end
    n_vec++; if (h !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div_hi: got %h want ffffffff", h); end
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, h, l, lat, bb);
    n_vec++; if (l !== 32'h8000_0000) begin n_err++; $display("FAIL div_ovf_lo: got %h want 80000000", l); end
    n_vec++; if (h !== 32'd0) begin n_err++; $display("FAIL div_ovf_hi: got %h want 0", h); end
`endif
    issue(OP_DIVU, 32'd7, 32'd2, h, l, lat, bb);
    n_vec++; if (l !== 32'd3) begin n_err++; $display("FAIL divu_lo: got %h want 3", l); end
    n_vec++; if (h !== 32'd1) begin n_err++; $display("FAIL divu_hi: got %h want 1", h); end
    issue(OP_DIVU, 32'd15, 32'd0, h, l, lat, bb);
    n_vec++; if (l !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL divz_lo: got %h want ffffffff", l); end
    n_vec++; if (h !== 32'h0000_000F) begin n_err++; $display("FAIL divz_hi: got %h want 0000000f", h); end
    n_vec++; if (lat !== 33) begin n_err++; $display("FAIL divz_latency: got %0d want 33", lat); end
  endtask

  task automatic test_random();
    logic [31:0] h, l, a, b;
    logic [63:0] exp;
    logic [1:0]  op;
    int lat, bb;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: a = 32'h8000_0000;
        1: a = 32'hFFFF_FFFF;
        2: a = 32'd0;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 6))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'd1;
        3: b = $urandom_range(1, 255);
        default: b = $urandom;
      endcase
      exp = model(op, a, b);
      issue(op, a, b, h, l, lat, bb);
      n_vec++; if ({h, l} !== exp) begin n_err++; $display("FAIL rand_result op=%0d a=%h b=%h: got %h_%h want %h", op, a, b, h, l, exp); end
      n_vec++; if (lat !== 33) begin n_err++; $display("FAIL rand_latency: got %0d want 33", lat); end
      repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      n_vec++; if ({bus.hi, bus.lo} !== exp) begin n_err++; $display("FAIL rand_hold: got %h_%h want %h", bus.hi, bus.lo, exp); end
    end
  endtask

  task automatic test_ignore_start();
    logic [31:0] h0, l0;
    int lat;
    h0 = bus.hi;
    l0 = bus.lo;
    bus.start = 1'b1;
    bus.op = OP_DIVU;
    bus.operand_a = 32'd100;
    bus.operand_b = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      if (k == 10) begin
        bus.start = 1'b1;
        bus.op = OP_MULTU;
        bus.operand_a = 32'd5;
        bus.operand_b = 32'd6;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (k == 20) begin
        n_vec++; if ({bus.hi, bus.lo} !== {h0, l0}) begin n_err++; $display("FAIL busy_hold: got %h_%h want %h_%h", bus.hi, bus.lo, h0, l0); end
      end
      if (bus.done) begin lat = k; break; end
    end
    n_vec++; if (lat !== 33) begin n_err++; $display("FAIL ignore_latency: got %0d want 33", lat); end
    n_vec++; if (bus.lo !== 32'd14) begin n_err++; $display("FAIL ignore_lo: got %h want 0000000e", bus.lo); end
    n_vec++; if (bus.hi !== 32'd2) begin n_err++; $display("FAIL ignore_hi: got %h want 00000002", bus.hi); end
    @(posedge clk); #1;
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL ignore_requeued: busy got %b want 0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] h, l;
    int lat1, lat2, bb;
    time t1, t2;
    issue(OP_DIVU, 32'd1000, 32'd10, h, l, lat1, bb);
    t1 = $time;
    n_vec++; if ({h, l} !== {32'd0, 32'd100}) begin n_err++; $display("FAIL b2b_first: got %h_%h want 00000000_00000064", h, l); end
    issue(OP_MULTU, 32'd7, 32'd9, h, l, lat2, bb);
    t2 = $time;
    n_vec++; if ({h, l} !== {32'd0, 32'd63}) begin n_err++; $display("FAIL b2b_second: got %h_%h want 00000000_0000003f", h, l); end
    n_vec++; if ((t2 - t1) / 10 !== 34) begin n_err++; $display("FAIL b2b_interval: got %0d want 34", (t2 - t1) / 10); end
  endtask

  task automatic test_rst_mid();
    int ndone;
    bus.start = 1'b1;
    bus.op = OP_DIV;
    bus.operand_a = 32'hFFFF_FC18;
    bus.operand_b = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    n_vec++; if (bus.hi !== 32'd0) begin n_err++; $display("FAIL rst_hi: got %h want 0", bus.hi); end
    n_vec++; if (bus.lo !== 32'd0) begin n_err++; $display("FAIL rst_lo: got %h want 0", bus.lo); end
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    n_vec++; if (ndone !== 0) begin n_err++; $display("FAIL rst_no_done: got %0d pulses want 0", ndone); end
    rst = 1'b1;
    bus.start = 1'b1;
    bus.op = OP_MULTU;
    bus.operand_a = 32'd3;
    bus.operand_b = 32'd4;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.start = 1'b0;
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_start_dropped: busy got %b want 0", bus.busy); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_multu_latency();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
